split_target_port_burst: RTL and testbench

- Parametrised successor to the single-byte split target port on the serial bus.
- Deserialises address and write-data frames of configurable width into a held request with a ready handshake to the target.
- Buffers read responses in a RESP_DEPTH-entry FIFO and serialises them back under arbiter grant.
- Split requests are issued automatically; a grant withdrawn mid-word pauses transmission without losing bits.

---
 rtl/split_target_port_burst.sv | 215 +++++++++++++++++++++
 tb/tb_split_target_port_burst.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/split_target_port_burst.sv
// ---------------------------------------------------------------------------
// split_target_port_burst
//
// Serial-bus split target port. Deserialises LSB-first address and write-data
// frames into a held request for the target, buffers the target's read
// responses in a small FIFO and serialises them back onto the bus while the
// arbiter grants it. The bus is requested automatically while responses wait.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   bus_data_in/_valid          serial input bit and its strobe
//   bus_mode                    1 = data frame bit, 0 = address frame bit
//   target_rw                   1 = write, 0 = read (sampled on last addr bit)
//   target_addr_in/_valid       held request address / valid
//   target_data_in/_valid       held write data (0 for reads) / valid
//   target_req_ready            target accepts the held request
//   target_data_out/_valid      response word push
//   target_data_out_ready       response FIFO not full
//   arbiter_grant               bus granted to this port
//   arbiter_split_req           bus wanted for a pending response
//   bus_data_out/_valid         serial response bit and its strobe
//   resp_count                  response FIFO occupancy
//   rx_drop_count               saturating count of dropped input bits
// ---------------------------------------------------------------------------
module split_target_port_burst #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int RESP_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          bus_data_in,
  input  logic                          bus_data_in_valid,
  input  logic                          bus_mode,
  input  logic                          target_rw,
  output logic [ADDR_W-1:0]             target_addr_in,
  output logic [DATA_W-1:0]             target_data_in,
  output logic                          target_addr_in_valid,
  output logic                          target_data_in_valid,
  input  logic                          target_req_ready,
  input  logic [DATA_W-1:0]             target_data_out,
  input  logic                          target_data_out_valid,
  output logic                          target_data_out_ready,
  input  logic                          arbiter_grant,
  output logic                          arbiter_split_req,
  output logic                          bus_data_out,
  output logic                          bus_data_out_valid,
  output logic [$clog2(RESP_DEPTH):0]   resp_count,
  output logic [7:0]                    rx_drop_count
);

  localparam int PTR_W  = $clog2(RESP_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int RX_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int RXC_W  = $clog2(RX_MAX);
  localparam int TXC_W  = $clog2(DATA_W + 1);

  localparam logic [1:0] S_ADDR = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [1:0]        rx_state;
  logic [RXC_W-1:0]  rx_cnt;
  logic [ADDR_W-1:0] addr_sr;
  logic [DATA_W-1:0] data_sr;

  logic [DATA_W-1:0] mem [RESP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic              tx_active;
  logic [DATA_W-1:0] tx_sr;
  logic [TXC_W-1:0]  tx_rem;

  logic rx_drop;
  logic push;
  logic pop;

  assign target_data_out_ready = (resp_count != CNT_W'(RESP_DEPTH));
  assign push              = target_data_out_valid && target_data_out_ready;
  assign pop               = !tx_active && arbiter_grant && (resp_count != '0);
  assign arbiter_split_req = (resp_count != '0) || tx_active;

  // A bit is lost while the serialiser owns the port, while a request is
  // held, or when a data-mode bit shows up where an address bit is expected.
  assign rx_drop = bus_data_in_valid &&
                   (tx_active || (rx_state == S_HOLD) ||
                    ((rx_state == S_ADDR) && bus_mode));

  // Receive: frame assembly and held request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state             <= S_ADDR;
      rx_cnt               <= '0;
      addr_sr              <= '0;
      data_sr              <= '0;
      target_addr_in       <= '0;
      target_data_in       <= '0;
      target_addr_in_valid <= 1'b0;
      target_data_in_valid <= 1'b0;
      rx_drop_count        <= 8'd0;
    end else begin
      if (rx_drop)
        rx_drop_count <= sat_inc(rx_drop_count);

      if ((rx_state == S_HOLD) && target_req_ready) begin
        rx_state             <= S_ADDR;
        target_addr_in_valid <= 1'b0;
        target_data_in_valid <= 1'b0;
      end

      if (bus_data_in_valid && !tx_active) begin
        case (rx_state)
          S_ADDR: begin
            if (!bus_mode) begin
              // Shift in from the top so the first bit lands at bit 0.
              addr_sr <= {bus_data_in, addr_sr[ADDR_W-1:1]};
              if (rx_cnt == RXC_W'(ADDR_W - 1)) begin
                rx_cnt <= '0;
                if (target_rw) begin
                  rx_state <= S_DATA;
                end else begin
                  rx_state             <= S_HOLD;
                  target_addr_in       <= {bus_data_in, addr_sr[ADDR_W-1:1]};
                  target_data_in       <= '0;
                  target_addr_in_valid <= 1'b1;
                  target_data_in_valid <= 1'b0;
                end
              end else begin
                rx_cnt <= rx_cnt + RXC_W'(1);
              end
            end
          end
          S_DATA: begin
            if (bus_mode) begin
              data_sr <= {bus_data_in, data_sr[DATA_W-1:1]};
              if (rx_cnt == RXC_W'(DATA_W - 1)) begin
                rx_cnt               <= '0;
                rx_state             <= S_HOLD;
                target_addr_in       <= addr_sr;
                target_data_in       <= {bus_data_in, data_sr[DATA_W-1:1]};
                target_addr_in_valid <= 1'b1;
                target_data_in_valid <= 1'b1;
              end else begin
                rx_cnt <= rx_cnt + RXC_W'(1);
              end
            end else begin
              // Address bit mid-data: abandon the write and treat this bit
              // as bit 0 of a fresh address frame.
              addr_sr  <= {bus_data_in, addr_sr[ADDR_W-1:1]};
              rx_cnt   <= RXC_W'(1);
              rx_state <= S_ADDR;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Response FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RESP_DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      resp_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= target_data_out;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   resp_count <= resp_count + CNT_W'(1);
        2'b01:   resp_count <= resp_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Transmit: load one word per grant, shift only while granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_active          <= 1'b0;
      tx_sr              <= '0;
      tx_rem             <= '0;
      bus_data_out       <= 1'b0;
      bus_data_out_valid <= 1'b0;
    end else if (!tx_active) begin
      bus_data_out_valid <= 1'b0;
      if (pop) begin
        tx_sr     <= mem[rd_ptr];
        tx_rem    <= TXC_W'(DATA_W);
        tx_active <= 1'b1;
      end
    end else if (arbiter_grant) begin
      bus_data_out       <= tx_sr[0];
      bus_data_out_valid <= 1'b1;
      tx_sr              <= tx_sr >> 1;
      tx_rem             <= tx_rem - TXC_W'(1);
      if (tx_rem == TXC_W'(1))
        tx_active <= 1'b0;
    end else begin
      // Grant withdrawn: hold position, keep the last driven bit on the wire.
      bus_data_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_split_target_port_burst.sv
// ---------------------------------------------------------------------------
// tb_split_target_port_burst
//
// Self-checking bench for split_target_port_burst with default parameters.
// Frames are built from random addresses/data; expected requests, responses
// and drop counts come from a plain behavioural model (queues and counters).
// ---------------------------------------------------------------------------
module tb_split_target_port_burst;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 8;
  localparam int RESP_DEPTH = 4;

  logic                 clk;
  logic                 rst_n;
  logic                 bus_data_in;
  logic                 bus_data_in_valid;
  logic                 bus_mode;
  logic                 target_rw;
  logic [ADDR_W-1:0]    target_addr_in;
  logic [DATA_W-1:0]    target_data_in;
  logic                 target_addr_in_valid;
  logic                 target_data_in_valid;
  logic                 target_req_ready;
  logic [DATA_W-1:0]    target_data_out;
  logic                 target_data_out_valid;
  logic                 target_data_out_ready;
  logic                 arbiter_grant;
  logic                 arbiter_split_req;
  logic                 bus_data_out;
  logic                 bus_data_out_valid;
  logic [2:0]           resp_count;
  logic [7:0]           rx_drop_count;

  split_target_port_burst #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESP_DEPTH(RESP_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_data_in(bus_data_in), .bus_data_in_valid(bus_data_in_valid),
    .bus_mode(bus_mode), .target_rw(target_rw),
    .target_addr_in(target_addr_in), .target_data_in(target_data_in),
    .target_addr_in_valid(target_addr_in_valid),
    .target_data_in_valid(target_data_in_valid),
    .target_req_ready(target_req_ready),
    .target_data_out(target_data_out),
    .target_data_out_valid(target_data_out_valid),
    .target_data_out_ready(target_data_out_ready),
    .arbiter_grant(arbiter_grant), .arbiter_split_req(arbiter_split_req),
    .bus_data_out(bus_data_out), .bus_data_out_valid(bus_data_out_valid),
    .resp_count(resp_count), .rx_drop_count(rx_drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int drops_model = 0;
  bit bits_q[$];
  int cyc_q[$];
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge, and every
  // valid serial output bit is recorded with its cycle number.
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
    if (bus_data_out_valid) begin
      bits_q.push_back(bus_data_out);
      cyc_q.push_back(cyc);
    end
  endtask

  task automatic add_drop(input int n);
    drops_model = (drops_model + n > 255) ? 255 : drops_model + n;
  endtask

  task automatic send_bit(input logic b, input logic mode, input logic rw);
    bus_data_in       = b;
    bus_data_in_valid = 1'b1;
    bus_mode          = mode;
    target_rw         = rw;
    tick;
    bus_data_in_valid = 1'b0;
  endtask

  // rw is randomised on every bit but the last, which is the one that counts.
  task automatic send_addr(input logic [15:0] a, input logic rw);
    for (int i = 0; i < ADDR_W; i++)
      send_bit(a[i], 1'b0, (i == ADDR_W - 1) ? rw : 1'($urandom));
  endtask

  task automatic send_data(input logic [7:0] d);
    for (int i = 0; i < DATA_W; i++)
      send_bit(d[i], 1'b1, 1'($urandom));
  endtask

  task automatic check_req(input string tag, input logic [15:0] ea,
                           input logic [7:0] ed, input logic ew);
    check({tag, "_addr_valid"}, 32'(target_addr_in_valid), 1);
    check({tag, "_addr"},       32'(target_addr_in), 32'(ea));
    check({tag, "_data_valid"}, 32'(target_data_in_valid), 32'(ew));
    check({tag, "_data"},       32'(target_data_in), ew ? 32'(ed) : 0);
  endtask

  // Request is held for 'hold' refused cycles, then accepted. Random bits
  // thrown at the port meanwhile must all be counted as drops.
  task automatic hold_and_accept(input logic [15:0] ea, input logic [7:0] ed,
                                 input logic ew, input int hold, input string tag);
    target_req_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      check_req(tag, ea, ed, ew);
      if ($urandom_range(0, 1) == 1) begin
        bus_data_in       = 1'($urandom);
        bus_mode          = 1'($urandom);
        bus_data_in_valid = 1'b1;
        add_drop(1);
      end
      tick;
      bus_data_in_valid = 1'b0;
    end
    check_req(tag, ea, ed, ew);
    target_req_ready = 1'b1;
    if ($urandom_range(0, 1) == 1) begin
      bus_data_in       = 1'($urandom);
      bus_mode          = 1'b0;
      bus_data_in_valid = 1'b1;
      add_drop(1);
    end
    tick;
    bus_data_in_valid = 1'b0;
    target_req_ready  = 1'b0;
    check({tag, "_addr_valid_clr"}, 32'(target_addr_in_valid), 0);
    check({tag, "_data_valid_clr"}, 32'(target_data_in_valid), 0);
    check({tag, "_drops"}, 32'(rx_drop_count), 32'(drops_model));
  endtask

  task automatic push_word(input logic [7:0] w);
    target_data_out       = w;
    target_data_out_valid = 1'b1;
    if (exp_q.size() < RESP_DEPTH) exp_q.push_back(w);
    tick;
    target_data_out_valid = 1'b0;
  endtask

  function automatic logic [7:0] word_at(input int base);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = bits_q[base + i];
    return v;
  endfunction

  task automatic do_reset;
    rst_n = 1'b0;
    #2;
    drops_model = 0;
    exp_q.delete();
    check("rst_addr_valid", 32'(target_addr_in_valid), 0);
    check("rst_data_valid", 32'(target_data_in_valid), 0);
    check("rst_addr", 32'(target_addr_in), 0);
    check("rst_data", 32'(target_data_in), 0);
    check("rst_resp_count", 32'(resp_count), 0);
    check("rst_ready", 32'(target_data_out_ready), 1);
    check("rst_split_req", 32'(arbiter_split_req), 0);
    check("rst_out_valid", 32'(bus_data_out_valid), 0);
    check("rst_out_bit", 32'(bus_data_out), 0);
    check("rst_drops", 32'(rx_drop_count), 0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    bits_q.delete();
    cyc_q.delete();
  endtask

  logic [15:0] a;
  logic [15:0] b;
  logic [7:0]  d;
  logic        rw;
  int          budget;
  int          nbits;

  initial begin
    rst_n = 1'b0;
    bus_data_in = 1'b0; bus_data_in_valid = 1'b0; bus_mode = 1'b0;
    target_rw = 1'b0; target_req_ready = 1'b0;
    target_data_out = '0; target_data_out_valid = 1'b0;
    arbiter_grant = 1'b0;
    #1;
    do_reset;

    // Read request
    send_addr(16'hA5C3, 1'b0);
    hold_and_accept(16'hA5C3, 8'h00, 1'b0, 3, "read");

    // Write request
    send_addr(16'h1234, 1'b1);
    check("write_mid_valid", 32'(target_addr_in_valid), 0);
    send_data(8'h5A);
    hold_and_accept(16'h1234, 8'h5A, 1'b1, 4, "write");

    // Random request frames
    for (int it = 0; it < 8; it++) begin
      a  = 16'($urandom);
      d  = 8'($urandom);
      rw = 1'($urandom);
      send_addr(a, rw);
      if (rw) begin
        check("rnd_mid_valid", 32'(target_addr_in_valid), 0);
        send_data(d);
      end
      hold_and_accept(a, d, rw, $urandom_range(0, 4), "rnd");
    end

    // Mode error inside a write: restart as a new address frame
    a = 16'($urandom);
    b = 16'($urandom) | 16'h0001;
    send_addr(a, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1'b1, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    for (int i = 1; i < ADDR_W; i++)
      send_bit(b[i], 1'b0, (i == ADDR_W - 1) ? 1'b0 : 1'($urandom));
    hold_and_accept(b, 8'h00, 1'b0, 1, "abort");

    // Data-mode bit in an idle address phase is only counted
    send_bit(1'($urandom), 1'b1, 1'b0);
    add_drop(1);
    check("idle_mode_drop", 32'(rx_drop_count), 32'(drops_model));
    check("idle_mode_valid", 32'(target_addr_in_valid), 0);
    a = 16'($urandom);
    send_addr(a, 1'b0);
    hold_and_accept(a, 8'h00, 1'b0, 0, "after_drop");

    // Response burst, grant held off while filling
    arbiter_grant = 1'b0;
    exp_q.delete();
    begin
      logic [7:0] words [4] = '{8'h81, 8'h3C, 8'hFF, 8'h00};
      for (int i = 0; i < 4; i++) begin
        push_word(words[i]);
        check("fill_count", 32'(resp_count), 32'(i + 1));
        check("fill_ready", 32'(target_data_out_ready), (i < 3) ? 1 : 0);
      end
    end
    push_word(8'hAA);
    check("full_count", 32'(resp_count), 4);
    check("full_split_req", 32'(arbiter_split_req), 1);
    bits_q.delete();
    cyc_q.delete();
    arbiter_grant = 1'b1;
    budget = 0;
    while (bits_q.size() < 32 && budget < 200) begin tick; budget++; end
    tick; tick; tick;
    arbiter_grant = 1'b0;
    check("burst_bits", 32'(bits_q.size()), 32);
    if (bits_q.size() == 32) begin
      for (int w = 0; w < 4; w++) begin
        check("burst_word", 32'(word_at(8 * w)), 32'(exp_q[w]));
        check("burst_contig", 32'(cyc_q[8 * w + 7] - cyc_q[8 * w]), 7);
        if (w > 0) check("burst_gap", 32'(cyc_q[8 * w] - cyc_q[8 * w - 1]), 2);
      end
    end
    check("burst_split_done", 32'(arbiter_split_req), 0);
    check("burst_count_done", 32'(resp_count), 0);
    exp_q.delete();

    // Grant withdrawn after three bits
    push_word(8'hB6);
    bits_q.delete();
    arbiter_grant = 1'b1;
    budget = 0;
    while (bits_q.size() < 3 && budget < 50) begin tick; budget++; end
    arbiter_grant = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin
        bus_data_in = 1'b1; bus_mode = 1'b0; bus_data_in_valid = 1'b1;
        add_drop(1);
      end
      tick;
      bus_data_in_valid = 1'b0;
      check("pause_valid", 32'(bus_data_out_valid), 0);
      check("pause_hold_bit", 32'(bus_data_out), 1);
    end
    check("pause_split_req", 32'(arbiter_split_req), 1);
    check("tx_drop", 32'(rx_drop_count), 32'(drops_model));
    arbiter_grant = 1'b1;
    budget = 0;
    while (bits_q.size() < 8 && budget < 50) begin tick; budget++; end
    tick; tick; tick;
    arbiter_grant = 1'b0;
    check("pause_bits", 32'(bits_q.size()), 8);
    if (bits_q.size() == 8) check("pause_word", 32'(word_at(0)), 32'hB6);
    check("pause_split_done", 32'(arbiter_split_req), 0);
    exp_q.delete();

    // Random bursts with a flickering grant
    for (int it = 0; it < 3; it++) begin
      exp_q.delete();
      bits_q.delete();
      arbiter_grant = 1'b0;
      for (int k = 0; k < $urandom_range(1, 6); k++) push_word(8'($urandom));
      check("rnd_fill_count", 32'(resp_count), 32'(exp_q.size()));
      nbits = 8 * exp_q.size();
      budget = 0;
      while (bits_q.size() < nbits && budget < 500) begin
        arbiter_grant = ($urandom_range(0, 3) != 0);
        tick;
        budget++;
      end
      arbiter_grant = 1'b0;
      tick; tick;
      check("rnd_bits", 32'(bits_q.size()), 32'(nbits));
      if (bits_q.size() == nbits)
        for (int w = 0; w < exp_q.size(); w++)
          check("rnd_word", 32'(word_at(8 * w)), 32'(exp_q[w]));
      check("rnd_count_done", 32'(resp_count), 0);
    end

    // Reset mid-address, then a clean read
    for (int i = 0; i < 7; i++) send_bit(1'($urandom), 1'b0, 1'b0);
    do_reset;
    a = 16'($urandom);
    send_addr(a, 1'b0);
    hold_and_accept(a, 8'h00, 1'b0, 1, "post_rst_addr");

    // Reset mid-transmit
    for (int k = 0; k < 3; k++) push_word(8'($urandom));
    bits_q.delete();
    arbiter_grant = 1'b1;
    budget = 0;
    while (bits_q.size() < 5 && budget < 50) begin tick; budget++; end
    check("pre_rst_tx_bits", 32'(bits_q.size()), 5);
    arbiter_grant = 1'b0;
    do_reset;
    a = 16'($urandom);
    send_addr(a, 1'b0);
    hold_and_accept(a, 8'h00, 1'b0, 2, "post_rst_tx");
    check("post_rst_no_tx", 32'(bits_q.size()), 0);

    // Drop counter saturation
    a = 16'($urandom);
    send_addr(a, 1'b0);
    target_req_ready = 1'b0;
    for (int k = 0; k < 300; k++) begin
      bus_data_in = 1'($urandom); bus_mode = 1'($urandom); bus_data_in_valid = 1'b1;
      add_drop(1);
      tick;
    end
    bus_data_in_valid = 1'b0;
    check("sat_drops", 32'(rx_drop_count), 255);
    check_req("sat_hold", a, 8'h00, 1'b0);
    hold_and_accept(a, 8'h00, 1'b0, 0, "sat");
    send_bit(1'b0, 1'b1, 1'b0);
    add_drop(1);
    check("sat_stays", 32'(rx_drop_count), 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
